// File: rtl/req_hold_arbiter_if.sv
// Handshake bundle between requester agents and the hold-until-grant arbiter.
// The master side is the requester population; the slave side is the arbiter.
interface req_hold_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [OW-1:0] owner;
  logic          busy;
  logic [N-1:0]  starve;
  logic [N-1:0]  viol;

  modport master (
    output req,
    input  gnt, owner, busy, starve, viol
  );

  modport slave (
    input  req,
    output gnt, owner, busy, starve, viol
  );
endinterface

// File: rtl/req_hold_arbiter.sv
// Round-robin arbiter with hold-until-grant requests, a per-grant hold limit,
// and sticky handshake monitors for starvation and early request withdrawal.
module req_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_WAIT = 8,
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  req_hold_arbiter_if.slave bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [OW-1:0] ptr, ptr_nx;
  logic [OW-1:0] owner_r, owner_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [N-1:0]  gnt_r, gnt_nx;
  logic [N-1:0]  req_q;
  logic [N-1:0]  starve_r, viol_r;
  logic [WW-1:0] w [N];

  logic          found;
  logic [OW-1:0] pick;

  // Circular priority search: first requester at or after ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 0; off < N; off++) begin
      logic [OW-1:0] idx;
      idx = OW'((int'(ptr) + off) % N);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state logic: grant from IDLE, release on drop or on hitting the hold limit.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner_r;
    hold_nx  = hold_cnt;
    gnt_nx   = gnt_r;
    case (state)
      IDLE: begin
        gnt_nx   = '0;
        owner_nx = '0;
        if (found) begin
          state_nx = GRANT;
          owner_nx = pick;
          gnt_nx   = N'(1) << pick;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        if (!bus.req[owner_r] || hold_cnt == HW'(MAX_HOLD - 1)) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          owner_nx = '0;
          ptr_nx   = (owner_r == OW'(N - 1)) ? '0 : owner_r + 1'b1;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        owner_nx = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner_r  <= '0;
      hold_cnt <= '0;
      gnt_r    <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner_r  <= owner_nx;
      hold_cnt <= hold_nx;
      gnt_r    <= gnt_nx;
    end
  end

  // Handshake monitors: saturating wait counters, sticky starve and withdrawal flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      starve_r <= '0;
      viol_r   <= '0;
      for (int i = 0; i < N; i++) w[i] <= '0;
    end else begin
      req_q <= bus.req;
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && !gnt_r[i]) begin
          if (w[i] != WW'(MAX_WAIT)) w[i] <= w[i] + 1'b1;
          if (w[i] == WW'(MAX_WAIT - 1)) starve_r[i] <= 1'b1;
        end else begin
          w[i] <= '0;
        end
        if (req_q[i] && !bus.req[i] && !gnt_r[i]) viol_r[i] <= 1'b1;
      end
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.owner  = owner_r;
  assign bus.busy   = |gnt_r;
  assign bus.starve = starve_r;
  assign bus.viol   = viol_r;
endmodule
